systolic_deskew: RTL

//  Output-side counterpart of the B-operand skew buffer: collects the diagonally

---
 rtl/systolic_pkg.sv | 14 +
 rtl/systolic_deskew_if.sv | 21 ++
 rtl/systolic_deskew_lane.sv | 34 +++
 rtl/systolic_deskew.sv | 77 +++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic result deskew path.
package systolic_pkg;
  localparam int DIM_DEF    = 8;
  localparam int BITS_C_DEF = 24;
  // Beat counter width for the default array size: beats 0 .. 2*DIM-2.
  localparam int CNT_W      = $clog2(2*DIM_DEF-1);

  typedef enum logic {IDLE, ACTIVE} deskew_state_t;

  // Beat counter width for an arbitrary array size.
  function automatic int cnt_w(input int dim);
    return $clog2(2*dim-1);
  endfunction
endpackage

// File: rtl/systolic_deskew_if.sv
// Handshake/data bundle between the MAC array side and the deskew block.
interface systolic_deskew_if
  import systolic_pkg::*;
#(
  parameter int BITS_C = BITS_C_DEF,
  parameter int DIM    = DIM_DEF
);
  localparam int ROW_W = $clog2(DIM);

  logic                     start;
  logic                     en;
  logic signed [BITS_C-1:0] Cin  [DIM-1:0];
  logic signed [BITS_C-1:0] Cout [DIM-1:0];
  logic                     vld;
  logic [ROW_W-1:0]         row;
  logic                     done;
  logic                     busy;

  modport master (output start, en, Cin, input Cout, vld, row, done, busy);
  modport slave  (input start, en, Cin, output Cout, vld, row, done, busy);
endinterface

// File: rtl/systolic_deskew_lane.sv
// One lane of the deskew: en-gated delay line of DEPTH stages, DEPTH=0 is a wire.
module deskew_lane #(
  parameter int BITS  = 24,
  parameter int DEPTH = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic signed [BITS-1:0] din,
  output logic signed [BITS-1:0] dout
);
  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
      // Clock/reset/enable are meaningless for a zero-depth lane.
      logic unused;
      assign unused = ^{clk, rst, en};
    end else begin : g_sr
      logic signed [BITS-1:0] sr [DEPTH];

      // Shift one stage per beat; a stall (en=0) freezes every stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
        end else if (en) begin
          sr[0] <= din;
          for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
        end
      end

      assign dout = sr[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/systolic_deskew.sv
// Re-aligns diagonally skewed result lanes from the MAC array into whole rows of C.
module systolic_deskew
  import systolic_pkg::*;
#(
  parameter int BITS_C = BITS_C_DEF,
  parameter int DIM    = DIM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  systolic_deskew_if.slave  bus
);
  localparam int CW    = $clog2(2*DIM-1);
  localparam int ROW_W = $clog2(DIM);
  // First beat with a complete row at the lane outputs, and the final beat.
  localparam logic [CW-1:0] FIRST = CW'(DIM-1);
  localparam logic [CW-1:0] LAST  = CW'(2*DIM-2);

  deskew_state_t          state;
  logic [CW-1:0]          cnt;
  logic                   shift;
  logic signed [BITS_C-1:0] lane_out [DIM];

  // Delay lines only advance on real beats of an active matrix.
  assign shift = (state == ACTIVE) && bus.en;

  // Lane i is i beats late, so it is delayed DIM-1-i beats to line up with lane DIM-1.
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    deskew_lane #(.BITS(BITS_C), .DEPTH(DIM-1-i)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (shift),
      .din  (bus.Cin[i]),
      .dout (lane_out[i])
    );
  end

  // Control FSM, beat counter and registered row outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.vld  <= 1'b0;
      bus.row  <= '0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
      for (int i = 0; i < DIM; i++) bus.Cout[i] <= '0;
    end else begin
      bus.vld  <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= ACTIVE;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end
        end
        ACTIVE: begin
          if (bus.en) begin
            cnt <= cnt + 1'b1;
            if (cnt >= FIRST) begin
              for (int i = 0; i < DIM; i++) bus.Cout[i] <= lane_out[i];
              bus.row <= ROW_W'(cnt - FIRST);
              bus.vld <= 1'b1;
            end
            if (cnt == LAST) begin
              state    <= IDLE;
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
